alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the core's combinational ALU, with a valid/ready handshake on both sides.
- Adds signed SLT, SLTU, SLL/SRL/SRA through an iterative shifter, and an optional iterative multiplier.
- Result is registered and held until the consumer accepts it.
- Sits between the decode/operand-fetch stage and writeback; a stall-capable execute stage uses it.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_shifter.sv | 56 +++++
 rtl/alu_seq.sv | 131 +++++++++++++
 tb/tb_alu_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encodings, FSM states, default width.
package alu_seq_pkg;

   localparam int DEFAULT_XLEN = 32;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_SLT  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_OR   = 4'b0101,
      OP_AND  = 4'b0110,
      OP_SLL  = 4'b0111,
      OP_SRL  = 4'b1000,
      OP_SRA  = 4'b1001,
      OP_MUL  = 4'b1010
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_e;

   function automatic logic is_shift(input alu_op_e op);
      return op inside {OP_SLL, OP_SRL, OP_SRA};
   endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative shifter: loads operand and amount on start, moves SHIFT_STEP bits per
// cycle (last step may be partial); done is high whenever no bits remain.
module alu_seq_shifter
   import alu_seq_pkg::*;
#(
   parameter int XLEN       = DEFAULT_XLEN,
   parameter int SHIFT_STEP = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  alu_op_e                   op,
   input  logic [XLEN-1:0]           data,
   input  logic [$clog2(XLEN)-1:0]   shamt,
   output logic                      done,
   output logic [XLEN-1:0]           result
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

   alu_op_e         op_q;
   logic [XLEN-1:0] sreg_q, sreg_d;
   logic [CW-1:0]   cnt_q, step;

   always_comb begin
      // NOTE: every output gets a value before the case, so no path can infer a latch.
      step   = (cnt_q > STEP) ? STEP : cnt_q;
      sreg_d = sreg_q >> step;
      case (op_q)
         OP_SLL:  sreg_d = sreg_q << step;
         OP_SRA:  sreg_d = $unsigned($signed(sreg_q) >>> step);
         default: sreg_d = sreg_q >> step;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_ADD;
         sreg_q <= '0;
         cnt_q  <= '0;
      end else if (start) begin
         op_q   <= op;
         sreg_q <= data;
         cnt_q  <= {1'b0, shamt};
      end else if (cnt_q != '0) begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_q - step;
      end
   end

   assign done   = (cnt_q == '0);
   assign result = sreg_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides; every op spends at least one EXEC cycle.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier on opcode 1010.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int XLEN       = DEFAULT_XLEN,
   parameter int SHIFT_STEP = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  logic [3:0]      i_alu_op,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_alu_data,
   output logic            o_busy
);

   localparam int SW = $clog2(XLEN);

   state_e          state_q, state_d;
   alu_op_e         op, op_q;
   logic [XLEN-1:0] a_q, b_q, data_q, data_d, exec_result, shift_result;
   logic            accept, shift_done, exec_done;

   assign op      = alu_op_e'(i_alu_op);
   assign o_ready = (state_q == S_IDLE) || (state_q == S_DONE && i_ready);
   assign accept  = i_valid && o_ready;

   // Started on every shift accept, so a zero amount finishes immediately with A as result.
   alu_seq_shifter #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_shifter (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .start  (accept && is_shift(op)),
      .op     (op),
      .data   (i_op_a),
      .shamt  (i_op_b[SW-1:0]),
      .done   (shift_done),
      .result (shift_result)
   );

`ifdef ALU_SEQ_MUL_EN
   logic [XLEN-1:0] mul_acc_q, mul_a_q, mul_b_q;
   logic [SW:0]     mul_cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mul_acc_q <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         mul_cnt_q <= '0;
      end else if (accept && op == OP_MUL) begin
         mul_acc_q <= '0;
         mul_a_q   <= i_op_a;
         mul_b_q   <= i_op_b;
         mul_cnt_q <= (SW+1)'(XLEN);
      end else if (mul_cnt_q != '0) begin
         if (mul_b_q[0]) mul_acc_q <= mul_acc_q + mul_a_q;
         mul_a_q   <= mul_a_q << 1;
         mul_b_q   <= mul_b_q >> 1;
         mul_cnt_q <= mul_cnt_q - 1'b1;
      end
   end

   assign exec_done = (op_q == OP_MUL) ? (mul_cnt_q == '0) : shift_done;
`else
   assign exec_done = shift_done;
`endif

   always_comb begin
      exec_result = '0;
      case (op_q)
         OP_ADD:  exec_result = a_q + b_q;
         OP_SUB:  exec_result = a_q - b_q;
         OP_SLT:  exec_result = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
         OP_SLTU: exec_result = {{(XLEN-1){1'b0}}, a_q < b_q};
         OP_XOR:  exec_result = a_q ^ b_q;
         OP_OR:   exec_result = a_q | b_q;
         OP_AND:  exec_result = a_q & b_q;
         OP_SLL, OP_SRL, OP_SRA: exec_result = shift_result;
`ifdef ALU_SEQ_MUL_EN
         OP_MUL:  exec_result = mul_acc_q;
`endif
         default: exec_result = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept)                            state_d = S_EXEC;
            else if (state_q == S_DONE && i_ready) state_d = S_IDLE;
         end
         S_EXEC: begin
            if (exec_done) begin
               state_d = S_DONE;
               data_d  = exec_result;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         if (accept) begin
            op_q <= op;
            a_q  <= i_op_a;
            b_q  <= i_op_b;
         end
      end
   end

   assign o_valid    = (state_q == S_DONE);
   assign o_busy     = (state_q != S_IDLE);
   assign o_alu_data = data_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (XLEN=32, SHIFT_STEP=1): result table plus handshake/reset sequences.
module tb_alu_seq;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        i_ready = 1'b1;
   logic [31:0] i_op_a = '0;
   logic [31:0] i_op_b = '0;
   logic [3:0]  i_alu_op = '0;
   logic        o_ready, o_valid, o_busy;
   logic [31:0] o_alu_data;

   int total = 0;
   int bad   = 0;
   vec_t vecs[$];

   alu_seq #(.XLEN(32), .SHIFT_STEP(1)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_op_a     (i_op_a),
      .i_op_b     (i_op_b),
      .i_alu_op   (i_alu_op),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_alu_data (o_alu_data),
      .o_busy     (o_busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one op (called #1 after an edge while o_ready=1), then count edges until o_valid.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      i_alu_op = op;
      i_op_a   = a;
      i_op_b   = b;
      i_valid  = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_op_a  = 32'hA5A5_A5A5;
      i_op_b  = 32'h5A5A_5A5A;
      lat = 0;
      while (!o_valid && lat < 100) begin
         @(posedge i_clk);
         #1;
         lat++;
      end
      res = o_alu_data;
   endtask

   function automatic void add(input string n, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input int lat);
      vec_t v;
      v.name = n; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
      vecs.push_back(v);
   endfunction

   initial begin
      logic [31:0] res;
      int          lat;

      add("add_wrap",   4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
      add("sub_wrap",   4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
      add("slt_neg",    4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
      add("sltu_big",   4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
      add("slt_pos",    4'b0010, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000, 1);
      add("sltu_small", 4'b0011, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0001, 1);
      add("op_unknown", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1);
      add("xor",        4'b0100, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1);
      add("or",         4'b0101, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1);
      add("and",        4'b0110, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
      add("sra_neg",    4'b1001, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 5);
      add("srl",        4'b1000, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 5);
      add("sra_pos",    4'b1001, 32'h7FFF_FFFF, 32'h0000_0003, 32'h0FFF_FFFF, 4);
      add("sll_31",     4'b0111, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32);
      add("sll_zero",   4'b0111, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1);
`ifdef ALU_SEQ_MUL_EN
      add("mul",        4'b1010, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 33);
`else
      add("mul_off",    4'b1010, 32'h0001_0003, 32'h0000_0005, 32'h0000_0000, 1);
`endif

      // Reset state, sampled while reset is held
      #12;
      check("rst_valid", {31'b0, o_valid}, 32'd0);
      check("rst_busy",  {31'b0, o_busy},  32'd0);
      check("rst_data",  o_alu_data,       32'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      check("rst_ready", {31'b0, o_ready}, 32'd1);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
         check({vecs[i].name, "_data"}, res, vecs[i].exp);
         check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      end

      // Backpressure: result held, new request ignored until consumer takes it
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      run_op(4'b0000, 32'd3, 32'd4, res, lat);
      check("bp_data", res, 32'd7);
      i_alu_op = 4'b0100;
      i_op_a   = 32'hF0F0_F0F0;
      i_op_b   = 32'hFFFF_FFFF;
      i_valid  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge i_clk);
         #1;
         check("bp_hold_valid", {31'b0, o_valid}, 32'd1);
         check("bp_hold_data",  o_alu_data,       32'd7);
         check("bp_hold_ready", {31'b0, o_ready}, 32'd0);
      end
      i_ready = 1'b1;
      #1;
      check("bp_ready_comb", {31'b0, o_ready}, 32'd1);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      check("bp_accept_busy",  {31'b0, o_busy},  32'd1);
      check("bp_accept_valid", {31'b0, o_valid}, 32'd0);
      @(posedge i_clk);
      #1;
      check("bp_next_valid", {31'b0, o_valid}, 32'd1);
      check("bp_next_data",  o_alu_data,       32'h0F0F_0F0F);
      @(posedge i_clk);
      #1;
      check("bp_idle", {31'b0, o_busy}, 32'd0);

      // Reset in the middle of a long shift
      i_alu_op = 4'b0111;
      i_op_a   = 32'h0000_0001;
      i_op_b   = 32'h0000_001F;
      i_valid  = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (10) @(posedge i_clk);
      #2;
      check("mid_exec_busy", {31'b0, o_busy}, 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("rst_exec_valid", {31'b0, o_valid}, 32'd0);
      check("rst_exec_busy",  {31'b0, o_busy},  32'd0);
      check("rst_exec_data",  o_alu_data,       32'd0);
      #4;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      run_op(4'b0110, 32'hFF00_FF00, 32'h0FF0_0FF0, res, lat);
      check("post_rst_and", res, 32'h0F00_0F00);
      check("post_rst_lat", lat, 32'd1);

      // Reset while a result is being held
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      run_op(4'b0000, 32'd10, 32'd20, res, lat);
      check("hold_data", res, 32'd30);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("rst_done_valid", {31'b0, o_valid}, 32'd0);
      check("rst_done_data",  o_alu_data,       32'd0);
      check("rst_done_ready", {31'b0, o_ready}, 32'd1);
      #4;
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      check("rst_done_idle", {31'b0, o_busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
